robs_control: RTL and testbench

Moore control unit for the signed Robertson's multiplier, directly upstream of `robs_datapath`.
- Accepts a start request.
- Sequences the datapath through load, per-bit add/subtract and arithmetic-shift steps by driving its 15-bit control vector `c`.
- Consumes the datapath status flags `zr` and `zq`.
- Reports completion with a one-cycle `done` pulse, after which `product` is valid.

---
 rtl/robs_pkg.sv | 93 +++++++++
 rtl/robs_control.sv | 80 ++++++++
 tb/tb_robs_control.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/robs_pkg.sv
// ============================================================================
// robs_pkg
// Shared state encoding, control-vector bit map and output decode for the
// Robertson's signed multiplier controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package robs_pkg;

    localparam int CTRL_W = 15;

    localparam int C_LD_Y    = 0;
    localparam int C_LD_CNT  = 1;
    localparam int C_CLR_A   = 2;
    localparam int C_LD_X    = 3;
    localparam int C_RH_LO   = 4;
    localparam int C_RH_HI   = 5;
    localparam int C_RL_SEL  = 6;
    localparam int C_X_SEL   = 7;
    localparam int C_LD_RH   = 8;
    localparam int C_LD_RL   = 9;
    localparam int C_ALU_ADD = 10;
    localparam int C_SR_ASR  = 11;
    localparam int C_SR_LD   = 12;
    localparam int C_CNT_DEC = 13;
    localparam int C_LD_A    = 14;

    localparam logic [1:0] RH_A   = 2'd0;
    localparam logic [1:0] RH_SR  = 2'd1;
    localparam logic [1:0] RH_ALU = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_INITR  = 4'd2,
        S_DEC    = 4'd3,
        S_TEST   = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_ALU_WB = 4'd7,
        S_SH_LD  = 4'd8,
        S_SH_AS  = 4'd9,
        S_SH_WB  = 4'd10,
        S_STORE  = 4'd11,
        S_DONE   = 4'd12
    } state_t;

    // op carries the add/sub choice into the write-back cycle so the ALU
    // opcode stays stable while its registered result is captured.
    function automatic logic [CTRL_W-1:0] ctrl_decode(input state_t s, input logic op);
        logic [CTRL_W-1:0] v;
        v = '0;
        case (s)
            S_LOAD: begin
                v[C_LD_Y]   = 1'b1;
                v[C_LD_CNT] = 1'b1;
                v[C_CLR_A]  = 1'b1;
                v[C_LD_X]   = 1'b1;
            end
            S_INITR: begin
                v[C_RH_HI:C_RH_LO] = RH_A;
                v[C_LD_RH]         = 1'b1;
                v[C_LD_RL]         = 1'b1;
            end
            S_DEC:    v[C_CNT_DEC] = 1'b1;
            S_ADD:    v[C_ALU_ADD] = 1'b1;
            S_ALU_WB: begin
                v[C_RH_HI:C_RH_LO] = RH_ALU;
                v[C_LD_RH]         = 1'b1;
                v[C_ALU_ADD]       = op;
            end
            S_SH_LD:  v[C_SR_LD]  = 1'b1;
            S_SH_AS:  v[C_SR_ASR] = 1'b1;
            S_SH_WB: begin
                v[C_RH_HI:C_RH_LO] = RH_SR;
                v[C_RL_SEL]        = 1'b1;
                v[C_LD_RH]         = 1'b1;
                v[C_LD_RL]         = 1'b1;
            end
            S_STORE: begin
                v[C_LD_A]  = 1'b1;
                v[C_LD_X]  = 1'b1;
                v[C_X_SEL] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/robs_control.sv
// ============================================================================
// robs_control
// Moore sequencer for the Robertson's signed multiplier datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module robs_control
    import robs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              zr,
    input  logic              zq,
    output logic [CTRL_W-1:0] c,
    output logic              busy,
    output logic              done
);

    // The iteration count lives in the datapath counter; here WIDTH only
    // guards against a degenerate configuration.
    if (WIDTH < 2) begin : g_width_check
        $error("robs_control: WIDTH must be at least 2");
    end

    state_t r_state;
    state_t w_next;
    logic   r_op;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_INITR;
            S_INITR:  w_next = S_DEC;
            S_DEC:    w_next = S_TEST;
            S_TEST: begin
                if (zr)      w_next = S_SH_LD;
                else if (zq) w_next = S_SUB;
                else         w_next = S_ADD;
            end
            S_ADD:    w_next = S_ALU_WB;
            S_SUB:    w_next = S_ALU_WB;
            S_ALU_WB: w_next = S_SH_LD;
            S_SH_LD:  w_next = S_SH_AS;
            S_SH_AS:  w_next = S_SH_WB;
            S_SH_WB:  w_next = zq ? S_STORE : S_DEC;
            S_STORE:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and never depend combinationally on the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            c       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_ADD)
                r_op <= 1'b1;
            else if (w_next == S_SUB)
                r_op <= 1'b0;
            c    <= ctrl_decode(w_next, r_op);
            busy <= (w_next != S_IDLE);
            done <= (w_next == S_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_robs_control.sv
// ============================================================================
// tb_robs_control
// Directed bench: controller driving a behavioural Robertson datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_robs_control;
    import robs_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              zr;
    logic              zq;
    logic [CTRL_W-1:0] c;
    logic              busy;
    logic              done;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    robs_control #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .zr   (zr),
        .zq   (zq),
        .c    (c),
        .busy (busy),
        .done (done)
    );

    // Behavioural datapath; R high carries a guard bit so the add/sub never overflows.
    logic        [7:0]  y_in, m_in;
    logic signed [7:0]  y;
    logic        [7:0]  x, a;
    logic        [16:0] r, sr;
    logic signed [8:0]  alu;
    logic        [3:0]  q;

    always @(posedge clk) begin
        if (c[0]) y <= y_in;
        if (c[1]) q <= 4'd8;
        else if (c[13]) q <= q - 4'd1;
        if (c[2]) a <= 8'h00;
        else if (c[14]) a <= r[15:8];
        if (c[3]) x <= c[7] ? r[7:0] : m_in;
        alu <= c[10] ? ($signed(r[16:8]) + y) : ($signed(r[16:8]) - y);
        if (c[12]) sr <= r;
        else if (c[11]) sr <= {sr[16], sr[16:1]};
        if (c[8]) begin
            case (c[5:4])
                2'd0:    r[16:8] <= {a[7], a};
                2'd1:    r[16:8] <= sr[16:8];
                default: r[16:8] <= alu;
            endcase
        end
        if (c[9]) r[7:0] <= c[6] ? sr[7:0] : x;
    end

    assign zr = ~r[0];
    assign zq = (q[2:0] == 3'd0);

    logic [CTRL_W-1:0] exp_c [0:79];
    int                exp_len;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [CTRL_W-1:0] v);
        exp_c[exp_len] = v;
        exp_len++;
    endtask

    task automatic build_trace(input logic [7:0] m);
        exp_len = 0;
        push(15'h000F);
        push(15'h0300);
        for (int i = 0; i < 8; i++) begin
            push(15'h2000);
            push(15'h0000);
            if (m[i]) begin
                if (i == 7) begin
                    push(15'h0000);
                    push(15'h0120);
                end else begin
                    push(15'h0400);
                    push(15'h0520);
                end
            end
            push(15'h1000);
            push(15'h0800);
            push(15'h0350);
        end
        push(15'h4088);
        push(15'h0000);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    // One multiply: cycle-exact trace, done cycle, product and idle afterwards.
    task automatic run(input string tag, input logic [7:0] yv, input logic [7:0] mv,
                       input logic [15:0] exp_prod, input bit pulse_mid, input bit hold);
        int n, bad, bad_cyc;
        logic [CTRL_W-1:0] bad_obs, bad_exp;
        bit pulsed;
        build_trace(mv);
        y_in = yv;
        m_in = mv;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n = 0; bad = 0; bad_cyc = 0; bad_obs = '0; bad_exp = '0; pulsed = 1'b0;
        forever begin
            n++;
            if (pulse_mid) begin
                start = (c == 15'h0800) && !pulsed;
                if (start) pulsed = 1'b1;
            end
            if (n > exp_len || c !== exp_c[n-1] || busy !== 1'b1 || done !== (n == exp_len)) begin
                if (bad == 0) begin
                    bad_cyc = n;
                    bad_obs = c;
                    bad_exp = (n <= exp_len) ? exp_c[n-1] : 15'h7FFF;
                end
                bad++;
            end
            if (done || n >= 100) break;
            @(posedge clk); #1;
        end
        if (bad != 0)
            $display("  %s first divergence at cycle %0d: c=%h want %h", tag, bad_cyc, bad_obs, bad_exp);
        chk({tag, " trace"}, bad, 0);
        chk({tag, " done_cycle"}, n, exp_len);
        chk({tag, " product"}, {16'h0, a, x}, {16'h0, exp_prod});
        @(posedge clk); #1;
        chk({tag, " idle_after"}, {29'h0, busy, done, (c != 0)}, 32'd0);
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, " relaunch_load"}, c, 15'h000F);
            start = 1'b0;
            wait_done({tag, " second"});
            chk({tag, " second_product"}, {16'h0, a, x}, {16'h0, exp_prod});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        y_in = 8'h00;
        m_in = 8'h00;
        #12;
        chk("reset c", c, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle no start", {busy, c}, 0);

        run("zero_bits",  8'h05, 8'h00, 16'h0000, 1'b0, 1'b0);
        run("all_bits",   8'h01, 8'hFF, 16'hFFFF, 1'b0, 1'b0);
        run("5x3",        8'h05, 8'h03, 16'h000F, 1'b0, 1'b0);
        run("m3x5",       8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b0);
        run("m128xm1",    8'h80, 8'hFF, 16'h0080, 1'b1, 1'b0);

        // Abort in the middle of an ADD step.
        y_in = 8'h03;
        m_in = 8'h03;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 30 && c != 15'h0400; i++) begin
            @(posedge clk); #1;
        end
        chk("reached ADD", c, 15'h0400);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset c", c, 0);
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        @(posedge clk); #1;
        chk("held reset", {done, busy, c}, 0);
        @(negedge clk);
        reset = 1'b1;
        run("after_reset", 8'h03, 8'h03, 16'h0009, 1'b0, 1'b0);

        run("held_start", 8'h05, 8'h03, 16'h000F, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
